// File: rtl/msk_hpc2_rnd_source_if.sv
// Seed and rnd handshake bundle of the HPC2 randomness source.
// slave = the source itself, master = TRNG/seed provider plus rnd consumer.
interface msk_hpc2_rnd_source_if #(
    parameter int RNDW = 1
);
    logic            seed_valid;
    logic            seed_ready;
    logic [63:0]     seed_in;
    logic            rnd_valid;
    logic            rnd_ready;
    logic [RNDW-1:0] rnd;
    logic            reseed_req;
    logic            fault;

    modport slave (
        input  seed_valid, seed_in, rnd_ready,
        output seed_ready, rnd_valid, rnd, reseed_req, fault
    );

    modport master (
        output seed_valid, seed_in, rnd_ready,
        input  seed_ready, rnd_valid, rnd, reseed_req, fault
    );
endinterface

// File: rtl/msk_hpc2_rnd_source.sv
// Seedable 64-bit LFSR delivering d*(d-1)/2 fresh bits per rnd transfer, with warm-up
// after each seed and a reseed request. MSK_RND_REPEAT_CHECK_EN adds a sticky repeat fault.
//
// state  | meaning
// IDLE   | no valid seed since reset, waiting for seed
// WARMUP | seed loaded, discarding WARMUP_CYCLES advances
// RUN    | rnd offered, advances once per accepted transfer
module msk_hpc2_rnd_source #(
    parameter int d               = 2,
    parameter int WARMUP_CYCLES   = 16,
    parameter int RESEED_INTERVAL = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    msk_hpc2_rnd_source_if.slave bus
);
    localparam int RNDW = d * (d - 1) / 2;
    localparam int WCW  = $clog2(WARMUP_CYCLES + 1);
    localparam int DCW  = $clog2(RESEED_INTERVAL + 1);
    localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_CYCLES - 1);
    localparam logic [DCW-1:0] DEL_MAX   = DCW'(RESEED_INTERVAL);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [63:0]    lfsr_q, lfsr_d;
    logic [WCW-1:0] warm_cnt_q, warm_cnt_d;
    logic [DCW-1:0] del_cnt_q, del_cnt_d;
    logic [DCW-1:0] del_next;
    logic           rnd_valid_q, rnd_valid_d;
    logic           seed_ready_q, seed_ready_d;
    logic           reseed_req_q, reseed_req_d;
    logic           seed_acc;
    logic           rnd_hs;
    logic [63:0]    seed_load;

`ifdef MSK_RND_REPEAT_CHECK_EN
    logic [RNDW-1:0] last_word_q, last_word_d;
    logic            have_last_q, have_last_d;
    logic [1:0]      rep_cnt_q, rep_cnt_d;
    logic            fault_q, fault_d;
    logic            word_repeat;
`endif

    // RNDW single steps unrolled so a whole fresh word appears per advance
    function automatic logic [63:0] lfsr_advance(input logic [63:0] s);
        logic [63:0] r;
        logic        b;
        r = s;
        for (int i = 0; i < RNDW; i++) begin
            b = r[63] ^ r[62] ^ r[60] ^ r[59];
            r = {r[62:0], b};
        end
        return r;
    endfunction

    assign seed_acc  = bus.seed_valid & seed_ready_q;
    assign rnd_hs    = rnd_valid_q & bus.rnd_ready;
    assign seed_load = (bus.seed_in == 64'h0) ? 64'h1 : bus.seed_in;
    assign del_next  = (del_cnt_q == DEL_MAX) ? DEL_MAX : del_cnt_q + DCW'(1);

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        warm_cnt_d   = warm_cnt_q;
        del_cnt_d    = del_cnt_q;
        rnd_valid_d  = rnd_valid_q;
        seed_ready_d = seed_ready_q;
        reseed_req_d = reseed_req_q;
`ifdef MSK_RND_REPEAT_CHECK_EN
        last_word_d  = last_word_q;
        have_last_d  = have_last_q;
        rep_cnt_d    = rep_cnt_q;
        fault_d      = fault_q;
        word_repeat  = have_last_q && (lfsr_q[RNDW-1:0] == last_word_q);
`endif
        // A seed beats a same-cycle rnd transfer; that word is consumed and the
        // delivered count restarts from the new seed anyway.
        if (seed_acc) begin
            state_d      = ST_WARMUP;
            lfsr_d       = seed_load;
            warm_cnt_d   = '0;
            del_cnt_d    = '0;
            rnd_valid_d  = 1'b0;
            seed_ready_d = 1'b0;
            reseed_req_d = 1'b0;
`ifdef MSK_RND_REPEAT_CHECK_EN
            have_last_d  = 1'b0;
            rep_cnt_d    = '0;
            fault_d      = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_WARMUP: begin
                    lfsr_d     = lfsr_advance(lfsr_q);
                    warm_cnt_d = warm_cnt_q + WCW'(1);
                    if (warm_cnt_q == WARM_LAST) begin
                        state_d      = ST_RUN;
                        rnd_valid_d  = 1'b1;
                        seed_ready_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (rnd_hs) begin
                        lfsr_d       = lfsr_advance(lfsr_q);
                        del_cnt_d    = del_next;
                        reseed_req_d = (del_next == DEL_MAX);
`ifdef MSK_RND_REPEAT_CHECK_EN
                        last_word_d  = lfsr_q[RNDW-1:0];
                        have_last_d  = 1'b1;
                        rep_cnt_d    = word_repeat ? rep_cnt_q + 2'd1 : 2'd0;
                        if (word_repeat && (rep_cnt_q == 2'd3)) begin
                            fault_d     = 1'b1;
                            rnd_valid_d = 1'b0;
                        end
`endif
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    rnd_valid_d  = 1'b0;
                    seed_ready_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lfsr_q       <= 64'h1;
            warm_cnt_q   <= '0;
            del_cnt_q    <= '0;
            rnd_valid_q  <= 1'b0;
            seed_ready_q <= 1'b1;
            reseed_req_q <= 1'b0;
`ifdef MSK_RND_REPEAT_CHECK_EN
            last_word_q  <= '0;
            have_last_q  <= 1'b0;
            rep_cnt_q    <= '0;
            fault_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            warm_cnt_q   <= warm_cnt_d;
            del_cnt_q    <= del_cnt_d;
            rnd_valid_q  <= rnd_valid_d;
            seed_ready_q <= seed_ready_d;
            reseed_req_q <= reseed_req_d;
`ifdef MSK_RND_REPEAT_CHECK_EN
            last_word_q  <= last_word_d;
            have_last_q  <= have_last_d;
            rep_cnt_q    <= rep_cnt_d;
            fault_q      <= fault_d;
`endif
        end
    end

    assign bus.rnd        = lfsr_q[RNDW-1:0];
    assign bus.rnd_valid  = rnd_valid_q;
    assign bus.seed_ready = seed_ready_q;
    assign bus.reseed_req = reseed_req_q;
`ifdef MSK_RND_REPEAT_CHECK_EN
    assign bus.fault      = fault_q;
`else
    assign bus.fault      = 1'b0;
`endif

endmodule

// File: tb/tb_msk_hpc2_rnd_source.sv
// Bench for msk_hpc2_rnd_source: d=2 and d=4 instances checked every cycle against a
// software model of the seed/warm-up/delivery rules, plus directed corner sequences.
module tb_msk_hpc2_rnd_source;
    localparam int WARM   = 16;
    localparam int RESEED = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    msk_hpc2_rnd_source_if #(.RNDW(1)) if2 ();
    msk_hpc2_rnd_source_if #(.RNDW(6)) if4 ();

    msk_hpc2_rnd_source #(.d(2), .WARMUP_CYCLES(WARM), .RESEED_INTERVAL(RESEED)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2)
    );
    msk_hpc2_rnd_source #(.d(4), .WARMUP_CYCLES(WARM), .RESEED_INTERVAL(RESEED)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model state, index 0 = d2 instance, index 1 = d4 instance
    logic [63:0] m_s[2];
    int          m_warm[2];
    bit          m_idle[2];
    int          m_del[2];
    bit          m_fault[2];
`ifdef MSK_RND_REPEAT_CHECK_EN
    logic [63:0] m_last[2];
    bit          m_have[2];
    int          m_rep[2];
`endif
    int          rw[2]    = '{1, 6};
    string       nm[2]    = '{"d2", "d4"};
    bit          m_chk[2] = '{1'b1, 1'b1};

    bit          in_sv[2];
    bit          in_rr[2];
    logic [63:0] in_seed[2];

    bit          cap_en = 1'b0;
    logic [63:0] cap_q[$];

    typedef struct {
        int n;
        bit rr;
        bit e_valid;
        bit e_sready;
        bit e_reseed;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] lfsr_run(input logic [63:0] s, input int n);
        logic [63:0] r;
        r = s;
        for (int k = 0; k < n; k++) r = {r[62:0], r[63] ^ r[62] ^ r[60] ^ r[59]};
        return r;
    endfunction

    function automatic bit exp_valid(input int i);
        return !m_idle[i] && (m_warm[i] == 0) && !m_fault[i];
    endfunction
    function automatic bit exp_sready(input int i);
        return m_idle[i] || (m_warm[i] == 0);
    endfunction
    function automatic logic [63:0] exp_rnd(input int i);
        return m_s[i] & ((64'h1 << rw[i]) - 64'h1);
    endfunction

    function automatic logic act_valid(input int i);
        return (i == 0) ? if2.rnd_valid : if4.rnd_valid;
    endfunction
    function automatic logic act_sready(input int i);
        return (i == 0) ? if2.seed_ready : if4.seed_ready;
    endfunction
    function automatic logic act_reseed(input int i);
        return (i == 0) ? if2.reseed_req : if4.reseed_req;
    endfunction
    function automatic logic act_fault(input int i);
        return (i == 0) ? if2.fault : if4.fault;
    endfunction
    function automatic logic [63:0] act_rnd(input int i);
        return (i == 0) ? 64'(if2.rnd) : 64'(if4.rnd);
    endfunction

    task automatic model_reset(input int i);
        m_s[i] = 64'h1; m_warm[i] = 0; m_idle[i] = 1'b1; m_del[i] = 0; m_fault[i] = 1'b0;
`ifdef MSK_RND_REPEAT_CHECK_EN
        m_have[i] = 1'b0; m_rep[i] = 0;
`endif
    endtask

    task automatic model_step(input int i);
        bit hs, acc;
        hs  = exp_valid(i) && in_rr[i];
        acc = in_sv[i] && exp_sready(i);
        if (acc) begin
            m_s[i]    = (in_seed[i] == 64'h0) ? 64'h1 : in_seed[i];
            m_warm[i] = WARM;
            m_idle[i] = 1'b0;
            m_del[i]  = 0;
            m_fault[i] = 1'b0;
`ifdef MSK_RND_REPEAT_CHECK_EN
            m_have[i] = 1'b0; m_rep[i] = 0;
`endif
        end else if (hs) begin
`ifdef MSK_RND_REPEAT_CHECK_EN
            m_rep[i] = (m_have[i] && exp_rnd(i) == m_last[i]) ? m_rep[i] + 1 : 0;
            if (m_rep[i] >= 4) m_fault[i] = 1'b1;
            m_last[i] = exp_rnd(i);
            m_have[i] = 1'b1;
`endif
            m_s[i] = lfsr_run(m_s[i], rw[i]);
            if (m_del[i] < RESEED) m_del[i]++;
        end else if (!m_idle[i] && m_warm[i] > 0) begin
            m_s[i] = lfsr_run(m_s[i], rw[i]);
            m_warm[i]--;
        end
    endtask

    // called #1 after a rising edge: check outputs, drive inputs, advance model
    task automatic cycle();
        for (int i = 0; i < 2; i++) begin
            if (m_chk[i]) begin
                check({nm[i], " rnd_valid"},  act_valid(i),  exp_valid(i));
                check({nm[i], " seed_ready"}, act_sready(i), exp_sready(i));
                check({nm[i], " reseed_req"}, act_reseed(i), m_del[i] >= RESEED);
                check({nm[i], " fault"},      act_fault(i),  m_fault[i]);
                if (exp_valid(i)) check({nm[i], " rnd"}, act_rnd(i), exp_rnd(i));
            end
        end
        if (cap_en && in_rr[0] && if2.rnd_valid) cap_q.push_back(64'(if2.rnd));
        if2.seed_valid = in_sv[0]; if2.seed_in = in_seed[0]; if2.rnd_ready = in_rr[0];
        if4.seed_valid = in_sv[1]; if4.seed_in = in_seed[1]; if4.rnd_ready = in_rr[1];
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        in_sv[0] = 1'b0; in_sv[1] = 1'b0;
        if2.seed_valid = 1'b0; if4.seed_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check({nm[i], " async rst rnd_valid"},  act_valid(i),  1'b0);
            check({nm[i], " async rst seed_ready"}, act_sready(i), 1'b1);
            check({nm[i], " async rst reseed_req"}, act_reseed(i), 1'b0);
            model_reset(i);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic capture_words(input string name, input int nwords);
        int guard;
        guard = 0;
        while (cap_q.size() < nwords && guard < 200) begin
            cycle();
            guard++;
        end
        check({name, " word count"}, cap_q.size(), nwords);
    endtask

    initial begin
        vec_t        tbl[7];
        logic [63:0] s1, s2;
        int          cnt;

        tbl[0] = '{0,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{15, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1,  1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{7,  1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1,  1'b1, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{5,  1'b0, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{3,  1'b1, 1'b1, 1'b1, 1'b1};

        for (int i = 0; i < 2; i++) begin
            in_sv[i] = 1'b0; in_rr[i] = 1'b0; in_seed[i] = 64'h0;
            model_reset(i);
        end
        if2.seed_valid = 1'b0; if2.seed_in = 64'h0; if2.rnd_ready = 1'b0;
        if4.seed_valid = 1'b0; if4.seed_in = 64'h0; if4.rnd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check({nm[i], " reset rnd_valid"},  act_valid(i),  1'b0);
            check({nm[i], " reset seed_ready"}, act_sready(i), 1'b1);
            check({nm[i], " reset reseed_req"}, act_reseed(i), 1'b0);
            check({nm[i], " reset fault"},      act_fault(i),  1'b0);
        end
        rst_n = 1'b1;

`ifndef MSK_RND_REPEAT_CHECK_EN
        // d=2 from seed 1 emits a long run of zeros, which the repeat check would flag
        in_sv[0] = 1'b1; in_seed[0] = 64'h1; in_rr[0] = 1'b1; cap_en = 1'b1;
        cycle();
        in_sv[0] = 1'b0;
        for (int v = 0; v < 7; v++) begin
            in_rr[0] = tbl[v].rr;
            repeat (tbl[v].n) cycle();
            check($sformatf("tbl%0d rnd_valid", v),  if2.rnd_valid,  tbl[v].e_valid);
            check($sformatf("tbl%0d seed_ready", v), if2.seed_ready, tbl[v].e_sready);
            check($sformatf("tbl%0d reseed_req", v), if2.reseed_req, tbl[v].e_reseed);
        end
        in_rr[0] = 1'b1;
        capture_words("seed1", 20);
        for (int k = 0; k < cap_q.size() && k < 20; k++)
            check($sformatf("seed1 word%0d", k), cap_q[k], 64'(lfsr_run(64'h1, WARM + k) & 64'h1));

        async_reset();
        cap_q.delete();
        in_sv[0] = 1'b1; in_seed[0] = 64'h0;
        cycle();
        in_sv[0] = 1'b0;
        capture_words("seed0", 20);
        for (int k = 0; k < cap_q.size() && k < 20; k++)
            check($sformatf("seed0 word%0d", k), cap_q[k], 64'(lfsr_run(64'h1, WARM + k) & 64'h1));
        cap_en = 1'b0;

        check("reseed_req before reseed", if2.reseed_req, 1'b1);
        in_sv[0] = 1'b1; in_seed[0] = {$urandom, $urandom} | 64'h1;
        cycle();
        in_sv[0] = 1'b0;
        check("reseed_req after reseed", if2.reseed_req, 1'b0);
        cnt = 0;
        while (!if2.rnd_valid && cnt < 40) begin
            cnt++;
            cycle();
        end
        check("reseed rnd_valid gap", cnt, 16);
`endif

        // d=4: reset during warm-up returns to IDLE and needs a fresh seed
        s1 = {$urandom, $urandom} | 64'h1;
        s2 = {$urandom, $urandom} | 64'h2;
        in_sv[1] = 1'b1; in_seed[1] = s1; in_rr[1] = 1'b1;
        cycle();
        in_sv[1] = 1'b0;
        repeat (5) cycle();
        check("d4 warmup seed_ready", if4.seed_ready, 1'b0);
        async_reset();
        repeat (20) cycle();
        check("d4 idle after reset", if4.rnd_valid, 1'b0);

        // d=4: seed and rnd handshake in the same cycle
        in_sv[1] = 1'b1; in_seed[1] = s1;
        cycle();
        in_sv[1] = 1'b0;
        repeat (19) cycle();
        check("d4 word before reseed", 64'(if4.rnd), lfsr_run(s1, 6 * (WARM + 3)) & 64'h3F);
        in_sv[1] = 1'b1; in_seed[1] = s2; in_rr[1] = 1'b1;
        cycle();
        in_sv[1] = 1'b0;
        check("d4 collide rnd_valid", if4.rnd_valid, 1'b0);
        check("d4 collide seed_ready", if4.seed_ready, 1'b0);
        cnt = 0;
        while (!if4.rnd_valid && cnt < 40) begin
            cnt++;
            cycle();
        end
        check("d4 collide gap", cnt, 16);
        check("d4 first word new seed", 64'(if4.rnd), lfsr_run(s2, 6 * WARM) & 64'h3F);

`ifdef MSK_RND_REPEAT_CHECK_EN
        m_chk[1] = 1'b0;
        force dut4.lfsr_q = {64{1'b1}};
        repeat (8) cycle();
        check("d4 fault set", if4.fault, 1'b1);
        check("d4 fault rnd_valid", if4.rnd_valid, 1'b0);
        check("d4 fault seed_ready", if4.seed_ready, 1'b1);
        release dut4.lfsr_q;
        in_sv[1] = 1'b1; in_seed[1] = s1;
        cycle();
        in_sv[1] = 1'b0;
        check("d4 fault cleared", if4.fault, 1'b0);
        m_chk[1] = 1'b1;
`endif

        // randomized traffic on both instances
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 2; i++) begin
                in_rr[i]   = ($urandom_range(0, 3) != 0);
                in_sv[i]   = ($urandom_range(0, 39) == 0);
                in_seed[i] = ($urandom_range(0, 7) == 0) ? 64'h0 : {$urandom, $urandom};
            end
            if ($urandom_range(0, 299) == 0) async_reset();
            else cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
